// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C target exposing a 256 x 8-bit register space through a simple register-file port.
//   Frame: START, {addr7,R/W}, pointer byte, data bytes; reads re-address with a repeated START.
//   Optional feature macro: I2C_SLAVE_GENERAL_CALL_EN (ACK 7'h00/W and silently discard its bytes).
// Ports:
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_sda, i_scl          asynchronous bus pad inputs
//   o_sda                 0 = pull SDA low, 1 = release
//   o_scl                 always released (no clock stretching)
//   o_reg_addr            register pointer
//   o_reg_wdata, o_reg_we write data and its 1-cycle strobe
//   o_reg_re, i_reg_rdata 1-cycle read strobe, data valid the following cycle
//   o_busy                high between an accepted START and STOP
module i2c_slave_regif #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
    parameter int         FILTER_LEN    = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sda,
    input  logic       i_scl,
    output logic       o_sda,
    output logic       o_scl,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy
);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam logic GC_EN = 1'b1;
`else
    localparam logic GC_EN = 1'b0;
`endif
    localparam int FW = $clog2(FILTER_LEN + 1);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_e;
    state_e state_q, state_d;
    // Bit 0 carries SCL, bit 1 carries SDA through synchroniser and filter.
    logic [1:0] s1_q, s2_q, flt_q, prv_q;
    logic [FW-1:0] fc_q [2];
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] sh_q, sh_d;
    logic [7:0] tx_q, tx_d, addr_q, addr_d, wdata_q, wdata_d;
    logic sda_q, sda_d, we_q, we_d, re_q, re_d, pend_q, pend_d, cap_q, cap_d;
    logic busy_q, busy_d, rw_q, rw_d, gc_q, gc_d, ack_q, ack_d;
    logic rise, fall, start, stop, done, hit, gc_hit, active, ack_bit;
    logic [7:0] rx;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q  <= '1;
            s2_q  <= '1;
            flt_q <= '1;
            prv_q <= '1;
            fc_q  <= '{default: '0};
        end else begin
            s1_q  <= {i_sda, i_scl};
            s2_q  <= s1_q;
            prv_q <= flt_q;
            // A new level is accepted only after FILTER_LEN consecutive differing samples.
            for (int k = 0; k < 2; k++) begin
                if (s2_q[k] == flt_q[k]) fc_q[k] <= '0;
                else if (fc_q[k] == FW'(FILTER_LEN - 1)) begin
                    flt_q[k] <= s2_q[k];
                    fc_q[k]  <= '0;
                end else fc_q[k] <= fc_q[k] + 1'b1;
            end
        end
    end
    assign rise    = flt_q[0] & ~prv_q[0];
    assign fall    = ~flt_q[0] & prv_q[0];
    assign start   = flt_q[0] & prv_q[0] & prv_q[1] & ~flt_q[1];
    assign stop    = flt_q[0] & prv_q[0] & ~prv_q[1] & flt_q[1];
    assign rx      = {sh_q, flt_q[1]};
    assign done    = rise & (cnt_q == 4'd7);
    assign hit     = (sh_q == SLAVE_ADDRESS);
    assign gc_hit  = GC_EN & (sh_q == 7'd0) & ~flt_q[1];
    assign active  = (state_q != IDLE) && (state_q != IGNORE);
    assign ack_bit = rise & (state_q == RD_ACK) & (cnt_q == 4'd8);
    always_ff @(posedge i_clk) state_q <= i_rst ? IDLE : state_d;
    // Byte states leave on the 8th SCL rise; ACK states leave on the 9th SCL fall.
    always_comb begin
        state_d = state_q;
        if (start) state_d = ADDR;
        else if (stop) state_d = IDLE;
        else if (done) begin
            case (state_q)
                ADDR:    state_d = (hit | gc_hit) ? ADDR_ACK : IGNORE;
                PTR:     state_d = PTR_ACK;
                WR_BYTE: state_d = WR_ACK;
                RD_BYTE: state_d = RD_ACK;
                default: ;
            endcase
        end else if (fall && cnt_q == 4'd9) begin
            case (state_q)
                ADDR_ACK:        state_d = rw_q ? RD_BYTE : PTR;
                PTR_ACK, WR_ACK: state_d = WR_BYTE;
                RD_ACK:          state_d = ack_q ? RD_BYTE : IGNORE;
                default: ;
            endcase
        end
    end
    always_comb begin
        cnt_d   = start ? 4'd0 : (rise && active) ? cnt_q + 4'd1 : (fall && cnt_q == 4'd9) ? 4'd0 : cnt_q;
        sh_d    = rise ? rx[6:0] : sh_q;
        rw_d    = (done && state_q == ADDR) ? flt_q[1] : rw_q;
        gc_d    = start ? 1'b0 : (done && state_q == ADDR) ? gc_hit : gc_q;
        ack_d   = ack_bit ? ~flt_q[1] : ack_q;
        we_d    = done && state_q == WR_BYTE && !gc_q;
        wdata_d = we_d ? rx : wdata_q;
        pend_d  = ack_bit & ~flt_q[1];
        // Read strobe after a matching R address, or one cycle after the pointer advances on a master ACK.
        re_d    = (done && state_q == ADDR && hit && flt_q[1]) || pend_q;
        cap_d   = re_q;
        tx_d    = cap_q ? i_reg_rdata : tx_q;
        addr_d  = (done && state_q == PTR && !gc_q) ? rx : (we_q || pend_d) ? addr_q + 8'd1 : addr_q;
        busy_d  = start ? 1'b1 : stop ? 1'b0 : busy_q;
        sda_d   = sda_q;
        if (start || stop) sda_d = 1'b1;
        else if (fall) begin
            case (state_q)
                ADDR_ACK, PTR_ACK, WR_ACK:
                    sda_d = (cnt_q == 4'd8) ? 1'b0 : (state_q == ADDR_ACK && rw_q) ? tx_q[7] : 1'b1;
                RD_ACK:  sda_d = (cnt_q == 4'd8) ? 1'b1 : ack_q ? tx_q[7] : 1'b1;
                RD_BYTE: sda_d = tx_q[~cnt_q[2:0]];
                default: sda_d = 1'b1;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sda_q   <= 1'b1;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            pend_q  <= 1'b0;
            cap_q   <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            gc_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sda_q   <= sda_d;
            we_q    <= we_d;
            re_q    <= re_d;
            pend_q  <= pend_d;
            cap_q   <= cap_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            gc_q    <= gc_d;
            ack_q   <= ack_d;
        end
    end
    assign o_sda       = sda_q;
    assign o_scl       = 1'b1;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_we    = we_q;
    assign o_reg_re    = re_q;
    assign o_busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: randomized bus-level bench for i2c_slave_regif against a register-space model.
module tb_i2c_slave_regif;
    localparam int Q = 8;
    logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic o_sda, o_scl, o_we, o_re, o_busy, sda_bus;
    logic [7:0] o_addr, o_wdata, rdata = 8'd0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [15:0] wlog [$];
    logic [7:0] rlog [$];
    logic [7:0] exp_ptr = 8'd0;
    int checks = 0, fails = 0, low_cnt = 0;
    assign sda_bus = sda_m & o_sda;
    always #5 clk = ~clk;
    i2c_slave_regif dut (
        .i_clk(clk), .i_rst(rst), .i_sda(sda_bus), .i_scl(scl_m),
        .o_sda(o_sda), .o_scl(o_scl), .o_reg_addr(o_addr), .o_reg_wdata(o_wdata),
        .o_reg_we(o_we), .o_reg_re(o_re), .i_reg_rdata(rdata), .o_busy(o_busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        else begin
            if (o_re) rdata <= mem[o_addr];
            if (o_we) mem[o_addr] <= o_wdata;
        end
    end
    always @(negedge clk) begin
        if (!o_sda) low_cnt++;
        if (!rst && o_we) wlog.push_back({o_addr, o_wdata});
        if (!rst && o_re) rlog.push_back(o_addr);
        if (!rst && (o_we || o_re)) check("strobe_excl", {31'd0, o_we & o_re}, 0);
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic start_c;
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
    endtask
    task automatic stop_c;
        sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2 * Q);
    endtask
    task automatic bit_c(input logic b, input logic g, output logic r);
        sda_m = b;
        tick(Q);
        if (g) begin
            scl_m = 1'b1; tick(2); scl_m = 1'b0; tick(Q);
        end
        scl_m = 1'b1; tick(Q);
        r = sda_bus;
        tick(Q); scl_m = 1'b0; tick(Q);
    endtask
    task automatic write_byte(input logic [7:0] d, input logic g, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_c(d[i], g && i == 3, r);
        bit_c(1'b1, 1'b0, ack);
    endtask
    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_c(1'b1, 1'b0, r);
            d[i] = r;
        end
        bit_c(nack, 1'b0, r);
    endtask
    task automatic do_write(input logic [7:0] p, input int n, input logic g, input logic [7:0] first);
        logic a;
        logic [7:0] d;
        logic [15:0] exp_w [$];
        int w0 = wlog.size();
        start_c;
        write_byte(8'hA0, 1'b0, a); check("addr_ack", {31'd0, a}, 0);
        check("busy_on", {31'd0, o_busy}, 1);
        write_byte(p, 1'b0, a); check("ptr_ack", {31'd0, a}, 0);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? first : 8'($urandom);
            write_byte(d, g, a); check("data_ack", {31'd0, a}, 0);
            ref_mem[8'(p + 8'(i))] = d;
            exp_w.push_back({8'(p + 8'(i)), d});
        end
        stop_c;
        check("busy_off", {31'd0, o_busy}, 0);
        check("we_count", wlog.size() - w0, n);
        for (int i = 0; i < n; i++) check("we_entry", {16'd0, wlog[w0 + i]}, {16'd0, exp_w[i]});
        exp_ptr = 8'(p + 8'(n));
        check("ptr_after_wr", {24'd0, o_addr}, {24'd0, exp_ptr});
    endtask
    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic a;
        logic [7:0] d;
        int r0 = rlog.size(), w0 = wlog.size();
        start_c;
        if (set_ptr) begin
            write_byte(8'hA0, 1'b0, a); check("raddr_w_ack", {31'd0, a}, 0);
            write_byte(p, 1'b0, a); check("rptr_ack", {31'd0, a}, 0);
            exp_ptr = p;
            start_c;
        end
        write_byte(8'hA1, 1'b0, a); check("raddr_r_ack", {31'd0, a}, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check("rd_data", {24'd0, d}, {24'd0, ref_mem[8'(exp_ptr + 8'(i))]});
        end
        check("sda_rel_nack", {31'd0, o_sda}, 1);
        stop_c;
        check("re_count", rlog.size() - r0, n);
        for (int i = 0; i < n; i++) check("re_addr", {24'd0, rlog[r0 + i]}, {24'd0, 8'(exp_ptr + 8'(i))});
        check("rd_no_we", wlog.size() - w0, 0);
        exp_ptr = 8'(exp_ptr + 8'(n - 1));
        check("ptr_after_rd", {24'd0, o_addr}, {24'd0, exp_ptr});
    endtask
    task automatic do_bad(input logic [6:0] ad, input logic rw);
        logic a;
        int w0 = wlog.size(), r0 = rlog.size(), l0 = low_cnt;
        start_c;
        write_byte({ad, rw}, 1'b0, a); check("bad_nack", {31'd0, a}, 1);
        if (!rw) begin
            write_byte(8'($urandom), 1'b0, a); check("bad_data_nack", {31'd0, a}, 1);
        end
        stop_c;
        check("bad_sda_never_low", low_cnt - l0, 0);
        check("bad_no_strobe", (wlog.size() - w0) + (rlog.size() - r0), 0);
        check("bad_ptr", {24'd0, o_addr}, {24'd0, exp_ptr});
    endtask
    task automatic do_gc;
        logic a;
        int w0 = wlog.size(), r0 = rlog.size();
        start_c;
        write_byte(8'h00, 1'b0, a);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        check("gc_ack", {31'd0, a}, 0);
        for (int i = 0; i < 2; i++) begin
            write_byte(8'($urandom), 1'b0, a); check("gc_data_ack", {31'd0, a}, 0);
        end
`else
        check("gc_nack", {31'd0, a}, 1);
`endif
        stop_c;
        start_c;
        write_byte(8'h01, 1'b0, a); check("gc_rd_nack", {31'd0, a}, 1);
        stop_c;
        check("gc_no_strobe", (wlog.size() - w0) + (rlog.size() - r0), 0);
        check("gc_ptr", {24'd0, o_addr}, {24'd0, exp_ptr});
    endtask
    task automatic do_partial(input logic [7:0] p);
        logic a, r;
        int w0 = wlog.size();
        start_c;
        write_byte(8'hA0, 1'b0, a); check("part_addr_ack", {31'd0, a}, 0);
        write_byte(p, 1'b0, a); check("part_ptr_ack", {31'd0, a}, 0);
        for (int i = 0; i < 4; i++) bit_c(1'($urandom), 1'b0, r);
        stop_c;
        exp_ptr = p;
        check("part_no_we", wlog.size() - w0, 0);
        check("part_busy", {31'd0, o_busy}, 0);
        check("part_ptr", {24'd0, o_addr}, {24'd0, exp_ptr});
    endtask
    task automatic do_rst_mid_ack;
        logic r;
        logic [7:0] b = 8'hA0;
        start_c;
        for (int i = 7; i >= 0; i--) bit_c(b[i], 1'b0, r);
        check("ack_driven", {31'd0, o_sda}, 0);
        rst = 1'b1;
        tick(1);
        check("rst_sda", {31'd0, o_sda}, 1);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_ptr", {24'd0, o_addr}, 0);
        rst = 1'b0;
        scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2 * Q);
        exp_ptr = 8'd0;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        tick(4);
        check("rst_o_sda", {31'd0, o_sda}, 1);
        check("rst_o_scl", {31'd0, o_scl}, 1);
        check("rst_addr", {24'd0, o_addr}, 0);
        check("rst_wdata", {24'd0, o_wdata}, 0);
        check("rst_we", {31'd0, o_we}, 0);
        check("rst_re", {31'd0, o_re}, 0);
        check("rst_busy0", {31'd0, o_busy}, 0);
        rst = 1'b0;
        tick(8);
        do_write(8'h10, 1, 1'b0, 8'hA5);
        check("mem_10", {24'd0, ref_mem[8'h10]}, 32'hA5);
        do_read(1'b1, 8'h20, 3);
        do_bad(7'h51, 1'b0);
        do_write(8'h30, 2, 1'b0, 8'h5A);
        do_write(8'hFF, 2, 1'b0, 8'h01);
        do_read(1'b1, 8'hFF, 2);
        do_partial(8'h44);
        do_write(8'h60, 3, 1'b1, 8'($urandom));
        do_gc;
        do_rst_mid_ack;
        do_read(1'b0, 8'h00, 2);
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0: do_write(8'($urandom), $urandom_range(1, 4), 1'($urandom), 8'($urandom));
                1: do_read(1'b1, 8'($urandom), $urandom_range(1, 3));
                2: do_read(1'b0, 8'h00, $urandom_range(1, 3));
                default: begin
                    logic [6:0] ad = 7'($urandom_range(1, 127));
                    if (ad == 7'h50) ad = 7'h51;
                    do_bad(ad, 1'($urandom));
                end
            endcase
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
